// File: rtl/mul_issue_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply issue controller: operation
// encodings, FSM states and the default busy-rise timeout.
package mul_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_MTHI  = 2'b10,
        OP_MTLO  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_WRITE
    } state_e;

    localparam int WAIT_MAX_DEFAULT = 8;

endpackage

// File: rtl/mul_sign_fix.sv
// Turns the signed 32x32 product from the shared multiplier into the unsigned
// product when requested; only the upper word needs correcting.
module mul_sign_fix (
    input  logic [63:0] prod,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_unsigned,
    output logic [63:0] fixed
);

    logic [31:0] corr;

    // Reinterpreting a negative operand as unsigned adds the other operand * 2^32
    always_comb begin
        corr = 32'd0;
        if (is_unsigned) begin
            corr = (a[31] ? b : 32'd0) + (b[31] ? a : 32'd0);
        end
        fixed = {prod[63:32] + corr, prod[31:0]};
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// HI/LO issue controller: handles MTHI/MTLO directly and sequences MULT/MULTU
// through an external signed multiplier via a start/busy handshake.
module mul_issue_ctrl
    import mul_issue_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    output logic        mul_start,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    input  logic [63:0] mul_z,
    input  logic        mul_busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        res_valid,
    output logic        stall
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    state_e         state_reg, state_next;
    logic [31:0]    a_reg, b_reg;
    logic           uns_reg;
    logic [63:0]    prod_reg;
    logic [31:0]    hi_reg, lo_reg;
    logic [CW-1:0]  cnt_reg;
    logic [63:0]    fixed;
    logic           xfer;

    mul_sign_fix u_sign_fix (
        .prod        (prod_reg),
        .a           (a_reg),
        .b           (b_reg),
        .is_unsigned (uns_reg),
        .fixed       (fixed)
    );

    assign xfer  = req_valid && (state_reg == ST_IDLE);
    assign mul_x = a_reg;
    assign mul_y = b_reg;
    assign hi    = hi_reg;
    assign lo    = lo_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            uns_reg   <= 1'b0;
            prod_reg  <= 64'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (xfer) begin
                case (req_op)
                    OP_MTHI: hi_reg <= req_a;
                    OP_MTLO: lo_reg <= req_a;
                    default: begin
                        a_reg   <= req_a;
                        b_reg   <= req_b;
                        uns_reg <= (req_op == OP_MULTU);
                    end
                endcase
            end
            // Counts cycles spent waiting for the multiplier to acknowledge
            if (state_reg == ST_WAIT_HI) begin
                cnt_reg <= cnt_reg + 1'b1;
            end else begin
                cnt_reg <= '0;
            end
            if (state_reg == ST_WAIT_LO && !mul_busy) begin
                prod_reg <= mul_z;
            end
            if (state_reg == ST_WRITE) begin
                hi_reg <= fixed[63:32];
                lo_reg <= fixed[31:0];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        mul_start  = 1'b0;
        res_valid  = 1'b0;
        stall      = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                stall     = 1'b0;
                if (req_valid && !req_op[1]) begin
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                mul_start  = 1'b1;
                state_next = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (mul_busy) begin
                    state_next = ST_WAIT_LO;
                end else if (cnt_reg == CW'(WAIT_MAX - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_LO: begin
                if (!mul_busy) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                res_valid  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a behavioural signed multiplier stub.
module tb_mul_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        req_ready;
    logic        mul_start;
    logic [31:0] mul_x, mul_y;
    logic [63:0] mul_z = 64'd0;
    logic        mul_busy = 1'b0;
    logic [31:0] hi, lo;
    logic        res_valid;
    logic        stall;

    int tests = 0;
    int fails = 0;

    // Multiplier stub: busy for stub_len cycles after mul_start, product valid with busy
    int   stub_len = 1;
    logic stub_en = 1'b1;
    int   stub_cnt = 0;

    mul_issue_ctrl #(.WAIT_MAX(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_start (mul_start),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_z     (mul_z),
        .mul_busy  (mul_busy),
        .hi        (hi),
        .lo        (lo),
        .res_valid (res_valid),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mul_start && stub_en) begin
            mul_z    <= $signed({{32{mul_x[31]}}, mul_x}) * $signed({{32{mul_y[31]}}, mul_y});
            mul_busy <= 1'b1;
            stub_cnt <= stub_len;
        end else if (stub_cnt > 1) begin
            stub_cnt <= stub_cnt - 1;
        end else begin
            stub_cnt <= 0;
            mul_busy <= 1'b0;
        end
    end

    task automatic test_reset;
        @(negedge clk);
        tests++;
        if (hi !== 32'd0 || lo !== 32'd0 || mul_x !== 32'd0 || mul_y !== 32'd0) begin
            fails++;
            $display("FAIL reset_regs: hi=%h lo=%h x=%h y=%h, required all 0", hi, lo, mul_x, mul_y);
        end
        tests++;
        if (mul_start !== 1'b0 || res_valid !== 1'b0 || stall !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ctrl: start=%b rv=%b stall=%b ready=%b, required 0 0 0 1",
                     mul_start, res_valid, stall, req_ready);
        end
        rst = 1'b0;
        $display("[TB] reset released hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_mult;
        logic [31:0] va [0:2] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] vb [0:2] = '{32'h00000005, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] eh [0:2] = '{32'hFFFFFFFF, 32'h00000000, 32'h40000000};
        logic [31:0] el [0:2] = '{32'hFFFFFFF1, 32'h00000001, 32'h00000000};
        int rv_at;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_op = 2'b00; req_a = va[i]; req_b = vb[i];
            tests++;
            if (req_ready !== 1'b1) begin
                fails++;
                $display("FAIL mult_ready[%0d]: got %b, required 1", i, req_ready);
            end
            rv_at = 0;
            for (int n = 1; n <= 6; n++) begin
                @(negedge clk);
                req_valid = 1'b0;
                if (n == 1) begin
                    tests++;
                    if (mul_start !== 1'b1 || mul_x !== va[i] || mul_y !== vb[i] || stall !== 1'b1) begin
                        fails++;
                        $display("FAIL mult_launch[%0d]: start=%b x=%h y=%h stall=%b, required 1 %h %h 1",
                                 i, mul_start, mul_x, mul_y, stall, va[i], vb[i]);
                    end
                end
                if (n == 2) begin
                    tests++;
                    if (mul_start !== 1'b0) begin
                        fails++;
                        $display("FAIL mult_start_pulse[%0d]: got %b in cycle 2, required 0", i, mul_start);
                    end
                end
                if (n == 4) begin
                    tests++;
                    if (mul_x !== va[i] || mul_y !== vb[i]) begin
                        fails++;
                        $display("FAIL mult_hold[%0d]: x=%h y=%h, required %h %h", i, mul_x, mul_y, va[i], vb[i]);
                    end
                end
                if (res_valid === 1'b1 && rv_at == 0) rv_at = n;
            end
            tests++;
            if (rv_at != 4 || hi !== eh[i] || lo !== el[i]) begin
                fails++;
                $display("FAIL mult[%0d]: res_valid at %0d hi=%h lo=%h, required 4 %h %h",
                         i, rv_at, hi, lo, eh[i], el[i]);
            end
            $display("[TB] MULT a=%h b=%h -> hi=%h lo=%h latency=%0d", va[i], vb[i], hi, lo, rv_at);
        end
    endtask

    task automatic test_multu;
        logic [31:0] va [0:2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] vb [0:2] = '{32'h00000002, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] eh [0:2] = '{32'h00000001, 32'hFFFFFFFE, 32'h40000000};
        logic [31:0] el [0:2] = '{32'hFFFFFFFE, 32'h00000001, 32'h00000000};
        int rv_at;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_op = 2'b01; req_a = va[i]; req_b = vb[i];
            rv_at = 0;
            for (int n = 1; n <= 6; n++) begin
                @(negedge clk);
                req_valid = 1'b0;
                if (res_valid === 1'b1 && rv_at == 0) rv_at = n;
            end
            tests++;
            if (rv_at != 4 || hi !== eh[i] || lo !== el[i]) begin
                fails++;
                $display("FAIL multu[%0d]: res_valid at %0d hi=%h lo=%h, required 4 %h %h",
                         i, rv_at, hi, lo, eh[i], el[i]);
            end
            $display("[TB] MULTU a=%h b=%h -> hi=%h lo=%h latency=%0d", va[i], vb[i], hi, lo, rv_at);
        end
    endtask

    task automatic test_mthi_mtlo;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b10; req_a = 32'h12345678; req_b = 32'h0;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL mthi_ready: got %b, required 1", req_ready);
        end
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || hi !== 32'h12345678 || res_valid !== 1'b0) begin
            fails++;
            $display("FAIL mthi: ready=%b hi=%h rv=%b, required 1 12345678 0", req_ready, hi, res_valid);
        end
        req_op = 2'b11; req_a = 32'h9ABCDEF0;
        @(negedge clk);
        req_valid = 1'b0;
        tests++;
        if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0 || res_valid !== 1'b0 || stall !== 1'b0) begin
            fails++;
            $display("FAIL mtlo: hi=%h lo=%h rv=%b stall=%b, required 12345678 9abcdef0 0 0",
                     hi, lo, res_valid, stall);
        end
        $display("[TB] MTHI/MTLO -> hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_back_to_back;
        int rv_at;
        int busy_ready;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b00; req_a = 32'h00000003; req_b = 32'h00000007;
        @(negedge clk);
        req_a = 32'hFFFF0000; req_b = 32'h00010000;
        busy_ready = 0;
        for (int n = 1; n <= 4; n++) begin
            if (n > 1) @(negedge clk);
            if (req_ready !== 1'b0) busy_ready++;
        end
        tests++;
        if (busy_ready != 0) begin
            fails++;
            $display("FAIL b2b_stall_ready: ready high in %0d stalled cycles, required 0", busy_ready);
        end
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || hi !== 32'h0 || lo !== 32'd21) begin
            fails++;
            $display("FAIL b2b_first: ready=%b hi=%h lo=%h, required 1 00000000 00000015", req_ready, hi, lo);
        end
        rv_at = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (n == 1) begin
                tests++;
                if (mul_start !== 1'b1 || mul_x !== 32'hFFFF0000) begin
                    fails++;
                    $display("FAIL b2b_second_launch: start=%b x=%h, required 1 ffff0000", mul_start, mul_x);
                end
            end
            if (res_valid === 1'b1 && rv_at == 0) rv_at = n;
        end
        tests++;
        if (rv_at != 4 || hi !== 32'hFFFFFFFF || lo !== 32'h00000000) begin
            fails++;
            $display("FAIL b2b_second: res_valid at %0d hi=%h lo=%h, required 4 ffffffff 00000000", rv_at, hi, lo);
        end
        $display("[TB] back-to-back MULT -> hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_reset_wait_lo;
        int rv_seen;
        stub_len = 3;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b00; req_a = 32'h00000011; req_b = 32'h00000022;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (stall !== 1'b1 || res_valid !== 1'b0) begin
            fails++;
            $display("FAIL wlo_pre: stall=%b rv=%b, required 1 0", stall, res_valid);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (hi !== 32'd0 || lo !== 32'd0 || stall !== 1'b0 || mul_x !== 32'd0 || res_valid !== 1'b0) begin
            fails++;
            $display("FAIL wlo_async_rst: hi=%h lo=%h stall=%b x=%h rv=%b, required 0 0 0 0 0",
                     hi, lo, stall, mul_x, res_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        rv_seen = 0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL wlo_ready_after_rst: got %b, required 1", req_ready);
        end
        for (int n = 0; n < 4; n++) begin
            if (res_valid !== 1'b0) rv_seen++;
            @(negedge clk);
        end
        tests++;
        if (rv_seen != 0 || hi !== 32'd0 || lo !== 32'd0) begin
            fails++;
            $display("FAIL wlo_no_write: rv cycles=%0d hi=%h lo=%h, required 0 0 0", rv_seen, hi, lo);
        end
        stub_len = 1;
        $display("[TB] reset in WAIT_LO -> hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_timeout;
        int rv_seen;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b10; req_a = 32'hAAAA5555;
        @(negedge clk);
        req_op = 2'b11; req_a = 32'h0F0F0F0F;
        @(negedge clk);
        stub_en = 1'b0;
        req_op = 2'b00; req_a = 32'h00000003; req_b = 32'h00000005;
        rv_seen = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (res_valid !== 1'b0) rv_seen++;
            if (n == 9) begin
                tests++;
                if (req_ready !== 1'b0 || stall !== 1'b1) begin
                    fails++;
                    $display("FAIL timeout_wait: ready=%b stall=%b in cycle 9, required 0 1", req_ready, stall);
                end
            end
            if (n == 10) begin
                tests++;
                if (req_ready !== 1'b1 || stall !== 1'b0) begin
                    fails++;
                    $display("FAIL timeout_idle: ready=%b stall=%b in cycle 10, required 1 0", req_ready, stall);
                end
            end
        end
        tests++;
        if (rv_seen != 0 || hi !== 32'hAAAA5555 || lo !== 32'h0F0F0F0F) begin
            fails++;
            $display("FAIL timeout_no_write: rv cycles=%0d hi=%h lo=%h, required 0 aaaa5555 0f0f0f0f",
                     rv_seen, hi, lo);
        end
        stub_en = 1'b1;
        $display("[TB] timeout -> hi=%h lo=%h", hi, lo);
    endtask

    initial begin
        test_reset;
        test_mult;
        test_multu;
        test_mthi_mtlo;
        test_back_to_back;
        test_reset_wait_lo;
        test_timeout;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul_issue_ctrl.md
MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  pipeline presents an HI/LO operation.
- req_op  input  2  operation: 00 MULT (signed), 01 MULTU (unsigned), 10 MTHI, 11 MTLO.
- req_a  input  32  rs operand.
- req_b  input  32  rt operand.
- req_ready  output  1  request accepted this cycle.
- mul_start  output  1  one-cycle launch pulse to the multiplier.
- mul_x  output  32  multiplicand to the multiplier.
- mul_y  output  32  multiplier operand to the multiplier.
- mul_z  input  64  signed product from the multiplier.
- mul_busy  input  1  multiplier busy.
- hi  output  32  HI register.
- lo  output  32  LO register.
- res_valid  output  1  one-cycle pulse when hi/lo update from a multiply.
- stall  output  1  multiply in flight.
REQ-002 Parameter WAIT_MAX, default 8: cycles allowed for mul_busy to rise after mul_start before abort.

Function
REQ-003 The FSM SHALL have the states IDLE, LAUNCH, WAIT_HI, WAIT_LO and WRITE.
REQ-004 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-005 A transfer SHALL occur when req_valid and req_ready are both 1.
REQ-006 MTHI/MTLO transfer: hi (or lo) = req_a at the next edge; FSM stays IDLE; res_valid stays 0.
REQ-007 MULT/MULTU transfer: latch req_a, req_b and the op into internal registers; go to LAUNCH.
REQ-008 LAUNCH: mul_start=1 for exactly one cycle, with mul_x/mul_y equal to the latched operands; go to WAIT_HI.
REQ-009 mul_x/mul_y SHALL hold the latched operands from LAUNCH until the return to IDLE.
REQ-010 WAIT_HI: on mul_busy=1 go to WAIT_LO.
REQ-011 WAIT_HI timeout: if mul_busy stays 0 for WAIT_MAX cycles, return to IDLE; hi/lo unchanged; res_valid not asserted.
REQ-012 WAIT_LO: on mul_busy=0 capture mul_z into an internal product register; go to WRITE.
REQ-013 WRITE: update hi/lo from the corrected product, pulse res_valid for one cycle, go to IDLE.
REQ-014 MULT: {hi,lo} = mul_z.
REQ-015 MULTU: {hi,lo} = mul_z + (a[31] ? b<<32 : 0) + (b[31] ? a<<32 : 0), computed modulo 2^64.
REQ-016 stall SHALL be 1 in LAUNCH, WAIT_HI, WAIT_LO and WRITE.
REQ-017 Minimum multiply latency, transfer to res_valid, SHALL be 4 cycles with a one-cycle mul_busy pulse.
REQ-018 mul_busy already 1 in IDLE or LAUNCH SHALL be ignored; only WAIT_HI samples its rise.
REQ-019 req_valid while stall=1 SHALL NOT be accepted; the requester holds its request.

Reset
REQ-020 On rst=1, asynchronously: FSM = IDLE; hi, lo, mul_x, mul_y and the product register = 0; mul_start, res_valid and stall = 0.
REQ-021 Reset in any state SHALL abort the operation with no hi/lo write.
REQ-022 The first request after reset deasserts SHALL be accepted in the first cycle.

Structure
REQ-023 A shared package SHALL hold the req_op encodings, the FSM state enumeration and the WAIT_MAX default.
REQ-024 The unsigned-correction adder of REQ-015 SHALL be a combinational sub-module, mul_sign_fix (64-bit in, 32-bit a/b, unsigned flag, 64-bit out).
REQ-025 The block SHALL instantiate no multiplier; it connects to the existing multiplier through the mul_* ports.

Verification
REQ-026 MULT a=FFFFFFFD, b=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1, res_valid 4 cycles after transfer.
REQ-027 MULTU a=FFFFFFFF, b=00000002 -> hi=00000001, lo=FFFFFFFE.
REQ-028 MTHI a=12345678, then MTLO a=9ABCDEF0 on consecutive cycles -> both accepted back-to-back; res_valid stays 0.
REQ-029 Second MULT held valid during stall -> req_ready=0 until IDLE; accepted the following cycle; hi/lo reflect the second product.
REQ-030 rst pulsed in WAIT_LO -> hi=lo=0, no res_valid, FSM IDLE, req_ready=1 the cycle after rst falls.
REQ-031 Multiplier stub never raises mul_busy -> return to IDLE after 8 cycles; hi/lo unchanged; no res_valid.
